// File: rtl/motor_bridge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : motor_bridge_ctrl
// Description : Control FSM for an H-bridge motor driver. It takes the direction,
//               enable, PWM and driver-fault inputs, which all arrive
//               asynchronously. It produces registered enable and half-bridge
//               controls. Two safety features are built in:
//               - Dead time is inserted whenever the direction is reversed.
//               - A filtered fault input forces the bridge off.
// Ports       : clk    - system clock, rising edge
//               rst    - asynchronous, active-low reset
//               dir    - direction command (1 = ina side), async
//               brk    - bridge enable (0 = coast), async
//               pwm    - PWM (1 = drive, 0 = brake), async
//               fs     - driver fault status, active-low, async
//               en     - bridge enable, registered
//               ina    - half-bridge A control, registered
//               inb    - half-bridge B control, registered
//               fault  - high while in FAULT, registered
//               state  - FSM code IDLE=0 DRIVE=1 DEAD=2 FAULT=3, registered
// Config      : MOTOR_FAULT_RETRY_EN
//               - Defined: FAULT auto-retries to IDLE after the
//                 RETRY_CYCLES hold-off.
//               - Undefined: FAULT latches until brk is low and fs is high.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_bridge_ctrl #(
    parameter int DT_CYCLES    = 8,
    parameter int FS_FILT      = 4,
    parameter int RETRY_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir,
    input  logic       brk,
    input  logic       pwm,
    input  logic       fs,
    output logic       en,
    output logic       ina,
    output logic       inb,
    output logic       fault,
    output logic [1:0] state
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_DEAD  = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    localparam logic [7:0] c_DT_LOAD = 8'(DT_CYCLES - 1);
    localparam logic [3:0] c_FS_LIM  = 4'(FS_FILT);

    // ------------------------------------------------------------------------
    // Two-flop synchronizers, bit order {fs, pwm, brk, dir}
    // ------------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic       w_ds;
    logic       w_bs;
    logic       w_ps;
    logic       w_fss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= {fs, pwm, brk, dir};
            r_sync2 <= r_sync1;
        end
    end

    assign w_ds  = r_sync2[0];
    assign w_bs  = r_sync2[1];
    assign w_ps  = r_sync2[2];
    assign w_fss = r_sync2[3];

    // ------------------------------------------------------------------------
    // Fault filter.
    // The fault is declared on the same edge that the counter reaches the
    // limit. This gives a filter of one sample (FS_FILT=1) the same 3-cycle
    // latency as every other input.
    // ------------------------------------------------------------------------
    logic [3:0] r_fcnt;
    logic [3:0] w_fcnt_nxt;
    logic       w_fault_det;

    always_comb begin
        w_fcnt_nxt = 4'd0;
        if (!w_fss) begin
            w_fcnt_nxt = (r_fcnt >= c_FS_LIM) ? c_FS_LIM : r_fcnt + 4'd1;
        end
    end

    assign w_fault_det = (w_fcnt_nxt == c_FS_LIM);

    // ------------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_dslat;
    logic       w_dslat_nxt;
    logic [7:0] r_dcnt;
    logic [7:0] w_dcnt_nxt;
    logic       w_en_nxt;
    logic       w_ina_nxt;
    logic       w_inb_nxt;
    logic       w_fault_nxt;

`ifdef MOTOR_FAULT_RETRY_EN
    localparam logic [15:0] c_RETRY_LOAD = 16'(RETRY_CYCLES - 1);
    logic [15:0] r_rcnt;
    logic [15:0] w_rcnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rcnt <= 16'd0;
        end else begin
            r_rcnt <= w_rcnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_dslat <= 1'b0;
            r_dcnt  <= 8'd0;
            r_fcnt  <= 4'd0;
            en      <= 1'b0;
            ina     <= 1'b0;
            inb     <= 1'b0;
            fault   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dslat <= w_dslat_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_fcnt  <= w_fcnt_nxt;
            en      <= w_en_nxt;
            ina     <= w_ina_nxt;
            inb     <= w_inb_nxt;
            fault   <= w_fault_nxt;
        end
    end

    assign state = r_state;

    // ------------------------------------------------------------------------
    // Next-state logic. Fault detection pre-empts every other transition.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dslat_nxt = r_dslat;
        w_dcnt_nxt  = r_dcnt;
`ifdef MOTOR_FAULT_RETRY_EN
        w_rcnt_nxt  = r_rcnt;
`endif
        if (w_fault_det) begin
            w_state_nxt = c_ST_FAULT;
`ifdef MOTOR_FAULT_RETRY_EN
            w_rcnt_nxt  = c_RETRY_LOAD;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_bs) begin
                        w_state_nxt = c_ST_DRIVE;
                        w_dslat_nxt = w_ds;
                    end
                end
                c_ST_DRIVE: begin
                    if (!w_bs) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (w_ds != r_dslat) begin
                        w_state_nxt = c_ST_DEAD;
                        w_dcnt_nxt  = c_DT_LOAD;
                    end
                end
                c_ST_DEAD: begin
                    // The counter runs to completion regardless of further dir
                    // activity. The direction is sampled only at expiry.
                    if (r_dcnt == 8'd0) begin
                        if (w_bs) begin
                            w_state_nxt = c_ST_DRIVE;
                            w_dslat_nxt = w_ds;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt - 8'd1;
                    end
                end
                default: begin
`ifdef MOTOR_FAULT_RETRY_EN
                    if (r_rcnt == 16'd0) begin
                        if (w_fss) begin
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_rcnt_nxt = c_RETRY_LOAD;
                        end
                    end else begin
                        w_rcnt_nxt = r_rcnt - 16'd1;
                    end
`else
                    if (!w_bs && w_fss) begin
                        w_state_nxt = c_ST_IDLE;
                    end
`endif
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode.
    // The decode is taken from the next state so that the outputs, fault and
    // state all register on the same edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_en_nxt    = 1'b0;
        w_ina_nxt   = 1'b0;
        w_inb_nxt   = 1'b0;
        w_fault_nxt = (w_state_nxt == c_ST_FAULT);
        if (w_state_nxt == c_ST_DRIVE) begin
            w_en_nxt  = 1'b1;
            w_ina_nxt = w_dslat_nxt | ~w_ps;
            w_inb_nxt = ~w_dslat_nxt | ~w_ps;
        end
    end

endmodule
`default_nettype wire

// File: doc/motor_bridge_ctrl.md
MOTOR_BRIDGE_CTRL -- requirements
Module: motor_bridge_ctrl

Interface
REQ-001 Parameter DT_CYCLES, default 8: dead-time length in clk cycles, range 1..255.
REQ-002 Parameter FS_FILT, default 4: consecutive low samples of fs that declare a fault, range 1..15.
REQ-003 Parameter RETRY_CYCLES, default 1024: fault hold-off before auto-retry, range 1..65535.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 dir  input  1  asynchronous direction command; 1 selects ina side.
REQ-007 brk  input  1  asynchronous bridge enable; 0 commands coast.
REQ-008 pwm  input  1  asynchronous PWM; 1 drives, 0 brakes.
REQ-009 fs  input  1  asynchronous driver fault status, active-low.
REQ-010 en  output  1  registered bridge enable.
REQ-011 ina  output  1  registered half-bridge A control.
REQ-012 inb  output  1  registered half-bridge B control.
REQ-013 fault  output  1  registered; 1 while the FAULT state is active.
REQ-014 state  output  2  registered FSM state code: IDLE=0, DRIVE=1, DEAD=2, FAULT=3.

Function
REQ-015 dir, brk, pwm and fs SHALL each pass a two-flop synchronizer; the synced values are ds, bs, ps and fss.
REQ-016 Latency from an input edge to an output change SHALL be exactly 3 clk cycles when no state transition intervenes.
REQ-017 In IDLE: en=0, ina=0, inb=0.
REQ-018 In DRIVE: en=1, ina=(ds_lat|!ps), inb=(!ds_lat|!ps), where ds_lat is the direction latched on entry to DRIVE.
REQ-019 In DEAD and FAULT: en=0, ina=0, inb=0.
REQ-020 IDLE->DRIVE when bs=1; ds_lat is loaded with ds.
REQ-021 DRIVE->IDLE when bs=0.
REQ-022 DRIVE->DEAD when bs=1 and ds differs from ds_lat; the dead counter is loaded with DT_CYCLES-1.
REQ-023 DEAD SHALL last exactly DT_CYCLES cycles, then go to DRIVE with ds_lat=ds, or to IDLE if bs=0 at expiry.
REQ-024 A ds toggle during DEAD SHALL NOT restart the counter; the final ds value at expiry is latched.
REQ-025 Fault filter: a 4-bit counter SHALL increment while fss=0, saturate at FS_FILT, and clear when fss=1.
REQ-026 Reaching FS_FILT SHALL force FAULT from any state and load the retry counter with RETRY_CYCLES-1.
REQ-027 Fault detection SHALL have priority over every other transition in the same cycle.
REQ-028 FAULT exit SHALL go to IDLE (never directly to DRIVE), and only when fss=1; exit timing is per REQ-031/032.
REQ-029 All counters SHALL saturate and never wrap; fault and state SHALL update in the same cycle as the outputs.

Reset
REQ-030 On rst=0, asynchronously: synchronizers=0, state=IDLE, en=ina=inb=0, fault=0, ds_lat=0, all counters=0; normal operation resumes on the first clk edge after rst=1, re-entering via IDLE even if reset was asserted mid-DEAD or mid-FAULT.

Configuration
REQ-031 With MOTOR_FAULT_RETRY_EN defined: FAULT SHALL exit to IDLE when the retry counter reaches 0 and fss=1; if fss=0 at expiry, FAULT holds and the counter reloads.
REQ-032 Without MOTOR_FAULT_RETRY_EN: the retry counter SHALL NOT be implemented, FAULT SHALL latch, and exit to IDLE SHALL occur only after bs=0 with fss=1.

Verification
REQ-033 rst release, brk=1, dir=1, pwm=1 -> en=1, ina=1, inb=0 on the 3rd clk after brk rises; state=1.
REQ-034 In DRIVE with dir=1, pwm=0 -> ina=1, inb=1 after 3 clk; pwm back to 1 -> ina=1, inb=0.
REQ-035 DT_CYCLES=8, dir toggles 1->0 in DRIVE -> en=ina=inb=0 for exactly 8 cycles, then en=1, ina=0, inb=1.
REQ-036 fs low for 3 cycles, then high -> no fault; fs low for 4 cycles -> fault=1 and outputs 0, including when asserted mid-DEAD.
REQ-037 MOTOR_FAULT_RETRY_EN, RETRY_CYCLES=16, fs released -> IDLE after 16 cycles, then DRIVE if brk=1; without the macro -> FAULT holds until brk=0.
REQ-038 rst asserted mid-DEAD -> outputs 0 immediately without waiting for clk; after release with brk=1, DRIVE follows via IDLE.
